// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master.
// Holds the state encoding and width/divider limits.
package spi_pkg;

   localparam int SPI_DATA_W  = 8;
   localparam int SPI_MIN_DIV = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_XFER  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_e;

endpackage

// File: rtl/spi_tick_div.sv
// SCK half-period divider for the SPI master.
// Counts 0..CLK_DIV-1; tick marks the terminal count.
module spi_tick_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(CLK_DIV - 1));

   // free-running counter, restarted on clear and on terminal count
   always_ff @(posedge clk) begin
      if (rst || clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, one word per start.
// FSM and shift register; timing from spi_tick_div.
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = SPI_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              keep_ss,
   input  logic [DATA_W-1:0] data_in,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] data_out,
   output logic              sck,
   output logic              mosi,
   input  logic              miso,
   output logic              ss
);

   if (CLK_DIV < SPI_MIN_DIV) begin : g_bad_div
      $error("spi_master: CLK_DIV must be at least %0d", SPI_MIN_DIV);
   end

   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_SETUP = ST_SETUP;
   localparam logic [2:0] S_XFER  = ST_XFER;
   localparam logic [2:0] S_HOLD  = ST_HOLD;
   localparam logic [2:0] S_GAP   = ST_GAP;

   localparam int HW = $clog2(2 * DATA_W);

   logic [2:0]        state;
   logic [2:0]        nxt;
   logic [DATA_W-1:0] sr;
   logic              rx_bit;
   logic              keep_q;
   logic [HW-1:0]     hcnt;
   logic              tick;
   logic              clr;
   logic              last_half;
   logic              last_fall;

   assign last_half = (hcnt == HW'(2 * DATA_W - 1));
   assign last_fall = (hcnt == HW'(2 * DATA_W - 2));
   assign clr       = (nxt != state);

   spi_tick_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick)
   );

   // next-state selection
   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:  if (start) nxt = S_SETUP;
         S_SETUP: if (tick) nxt = S_XFER;
         S_XFER:  if (tick && last_half) nxt = S_HOLD;
         S_HOLD:  if (tick) nxt = keep_q ? S_IDLE : S_GAP;
         S_GAP:   if (tick) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // state register, shifter and registered SPI outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         sr       <= '0;
         rx_bit   <= 1'b0;
         keep_q   <= 1'b0;
         hcnt     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_out <= '0;
         sck      <= 1'b0;
         mosi     <= 1'b0;
         ss       <= 1'b1;
      end else begin
         state <= nxt;
         done  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  sr     <= data_in;
                  keep_q <= keep_ss;
                  ss     <= 1'b0;
                  mosi   <= data_in[DATA_W-1];
                  busy   <= 1'b1;
                  hcnt   <= '0;
               end
            end
            S_SETUP: begin
               if (tick) begin
                  sck    <= 1'b1;
                  rx_bit <= miso;
               end
            end
            S_XFER: begin
               if (tick) begin
                  hcnt <= hcnt + 1'b1;
                  if (sck) begin
                     sck <= 1'b0;
                     sr  <= {sr[DATA_W-2:0], rx_bit};
                     if (!last_fall) mosi <= sr[DATA_W-2];
                  end else if (!last_half) begin
                     sck    <= 1'b1;
                     rx_bit <= miso;
                  end
               end
            end
            S_HOLD: begin
               if (tick) begin
                  data_out <= sr;
                  done     <= 1'b1;
                  if (keep_q) busy <= 1'b0;
                  else ss <= 1'b1;
               end
            end
            S_GAP: begin
               if (tick) busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master.
// Two instances: default divider and CLK_DIV=2.
`timescale 1ns/1ps
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       keep_ss;
   logic [7:0] data_in;
   logic       busy;
   logic       done;
   logic [7:0] data_out;
   logic       sck;
   logic       mosi;
   logic       miso;
   logic       ss;

   logic       start2;
   logic       keep_ss2;
   logic [7:0] data_in2;
   logic       busy2;
   logic       done2;
   logic [7:0] data_out2;
   logic       sck2;
   logic       mosi2;
   logic       miso2;
   logic       ss2;

   logic       slave_en;
   logic [7:0] slave_byte;
   logic [7:0] slave_sh;
   logic [3:0] nfall;
   logic [7:0] slave_rx;

   int total = 0;
   int fails = 0;

   int done_cnt, done_at, busy_fall, ss_fall, ss_rise;
   int rises, sck_bad, mosi_bad;
   logic [7:0] dout_at;
   logic snap_ss, snap_sck, snap_busy;
   logic [7:0] snap_dout;
   int d2_done, r1, r2, nr;
   logic [7:0] d2_out;
   logic p2sck;

   always #5 clk = ~clk;

   spi_master u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .keep_ss  (keep_ss),
      .data_in  (data_in),
      .busy     (busy),
      .done     (done),
      .data_out (data_out),
      .sck      (sck),
      .mosi     (mosi),
      .miso     (miso),
      .ss       (ss)
   );

   spi_master #(.CLK_DIV(2)) u_dut2 (
      .clk      (clk),
      .rst      (rst),
      .start    (start2),
      .keep_ss  (keep_ss2),
      .data_in  (data_in2),
      .busy     (busy2),
      .done     (done2),
      .data_out (data_out2),
      .sck      (sck2),
      .mosi     (mosi2),
      .miso     (miso2),
      .ss       (ss2)
   );

   // mode-0 slave: shifts out on falling sck, captures on rising sck
   always @(negedge sck or posedge ss) begin
      if (ss) nfall <= '0;
      else nfall <= nfall + 1'b1;
   end

   always @(posedge sck) begin
      if (!ss) slave_rx <= {slave_rx[6:0], mosi};
   end

   assign slave_sh = slave_byte << nfall;
   assign miso     = slave_en ? slave_sh[7] : mosi;
   assign miso2    = 1'b0;
   assign keep_ss2 = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [7:0] d, input logic k);
      @(posedge clk);
      #1;
      data_in = d;
      keep_ss = k;
      start   = 1'b1;
   endtask

   // steps cycles 1..n of a transfer started at cycle 0
   task automatic run(input int n, input int p1, input int p2,
                      input int rc, input bit stop);
      logic pb, pss, psck, pmosi;
      int len;
      done_cnt = 0; done_at = -1; busy_fall = -1;
      ss_fall = -1; ss_rise = -1; rises = 0;
      sck_bad = 0; mosi_bad = 0; dout_at = '0;
      pb = busy; pss = ss; psck = sck; pmosi = mosi; len = 0;
      for (int c = 1; c <= n; c++) begin
         @(posedge clk);
         #1;
         start = (c == p1) || (c == p2);
         rst   = (c == rc);
         if (c == 1) data_in = 8'h00;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
            dout_at = data_out;
         end
         if (pb && !busy && busy_fall < 0) busy_fall = c;
         if (pss && !ss && ss_fall < 0) ss_fall = c;
         if (!pss && ss && ss_rise < 0) ss_rise = c;
         if (sck == psck) begin
            len++;
         end else begin
            if (psck && len != 4) sck_bad++;
            if (!psck && rises > 0 && len != 4) sck_bad++;
            if (sck) rises++;
            len = 1;
         end
         if (!psck && sck && mosi !== pmosi) mosi_bad++;
         if (c == rc + 1) begin
            snap_ss = ss; snap_sck = sck;
            snap_busy = busy; snap_dout = data_out;
         end
         pb = busy; pss = ss; psck = sck; pmosi = mosi;
         if (stop && done) break;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; keep_ss = 1'b0; data_in = '0;
      start2 = 1'b0; data_in2 = '0;
      slave_en = 1'b0; slave_byte = 8'h3C; slave_rx = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_sck", sck, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_ss", ss, 1);
      rst = 1'b0;

      do_start(8'hA5, 1'b0);
      run(90, -1, -1, -1, 1'b0);
      chk("lb_done_at", done_at, 73);
      chk("lb_dout", dout_at, 8'hA5);
      chk("lb_rises", rises, 8);
      chk("lb_sck_width", sck_bad, 0);
      chk("lb_ss_fall", ss_fall, 1);
      chk("lb_ss_rise", ss_rise, 73);
      chk("lb_busy_fall", busy_fall, 77);

      slave_en = 1'b1;
      do_start(8'hC3, 1'b0);
      run(90, -1, -1, -1, 1'b0);
      chk("sl_rx", slave_rx, 8'hC3);
      chk("sl_dout", dout_at, 8'h3C);
      chk("sl_mosi_stable", mosi_bad, 0);
      slave_en = 1'b0;

      do_start(8'h12, 1'b1);
      run(90, -1, -1, -1, 1'b1);
      chk("b1_done_at", done_at, 73);
      chk("b1_dout", dout_at, 8'h12);
      chk("b1_busy_fall", busy_fall, 73);
      chk("b1_ss_rise", ss_rise, -1);
      data_in = 8'h34;
      keep_ss = 1'b0;
      start   = 1'b1;
      run(90, -1, -1, -1, 1'b0);
      chk("b2_done_at", done_at, 73);
      chk("b2_dout", dout_at, 8'h34);
      chk("b2_ss_fall", ss_fall, -1);
      chk("b2_ss_rise", ss_rise, 73);
      chk("b2_busy_fall", busy_fall, 77);

      do_start(8'h66, 1'b0);
      run(100, 10, 40, -1, 1'b0);
      chk("ig_done_cnt", done_cnt, 1);
      chk("ig_busy_fall", busy_fall, 77);
      chk("ig_dout", dout_at, 8'h66);

      do_start(8'h99, 1'b0);
      run(100, -1, -1, 30, 1'b0);
      chk("rs_ss", snap_ss, 1);
      chk("rs_sck", snap_sck, 0);
      chk("rs_busy", snap_busy, 0);
      chk("rs_dout", snap_dout, 0);
      chk("rs_no_done", done_cnt, 0);
      do_start(8'h5A, 1'b0);
      run(90, -1, -1, -1, 1'b0);
      chk("rs_new_done_at", done_at, 73);
      chk("rs_new_dout", dout_at, 8'h5A);

      @(posedge clk);
      #1;
      data_in2 = 8'hFF;
      start2   = 1'b1;
      d2_done = -1; r1 = -1; r2 = -1; nr = 0; d2_out = 8'hEE;
      p2sck = sck2;
      for (int c = 1; c <= 50; c++) begin
         @(posedge clk);
         #1;
         start2 = 1'b0;
         if (done2 && d2_done < 0) begin
            d2_done = c;
            d2_out  = data_out2;
         end
         if (!p2sck && sck2) begin
            nr++;
            if (r1 < 0) r1 = c;
            else if (r2 < 0) r2 = c;
         end
         p2sck = sck2;
      end
      chk("d2_done_at", d2_done, 37);
      chk("d2_dout", d2_out, 8'h00);
      chk("d2_rise1", r1, 3);
      chk("d2_rise2", r2, 7);
      chk("d2_rises", nr, 8);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master, MSB first, one 8-bit full-duplex transfer per start.
- Drives off-board or on-board SPI slaves, including the existing FPGA SPI slave block for loopback.
- Sits on the 50 MHz system clock beside the UART and VGA blocks; the host logic supplies bytes and collects the received bytes.

Parameters:
- CLK_DIV, 4: SCK half-period in clk cycles. Legal range is 2 or more; an elaboration-time error is raised otherwise.
- DATA_W, 8: transfer width in bits.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: transfer request. Sampled only in IDLE.
- keep_ss, input, 1: sampled with start. When 1, ss stays asserted after this transfer so bursts are possible.
- data_in, input, DATA_W: byte to transmit. Sampled with start.
- busy, output, 1: high from the cycle after an accepted start until the master can accept the next start.
- done, output, 1: one-cycle pulse when data_out is valid.
- data_out, output, DATA_W: received byte. Held until the next done.
- sck, output, 1: SPI clock. Idles low (CPOL=0).
- mosi, output, 1: serial data out.
- miso, input, 1: serial data in.
- ss, output, 1: active-low slave select.

Behaviour:
- Reset values: busy=0, done=0, data_out=0, sck=0, mosi=0, ss=1; state is IDLE.
- Reset mid-transfer aborts immediately: no done pulse, ss rises on the next edge.
- States: IDLE, SETUP, XFER, HOLD, GAP.
- A divider counter counts 0..CLK_DIV-1. Its terminal count is "tick". The counter is cleared on every state entry.
- IDLE:
  - start=1 loads the shift register with data_in, latches keep_ss, drives ss=0, mosi=data_in[MSB], busy=1, and enters SETUP.
  - start=0 leaves outputs unchanged (ss may already be low from a kept burst).
- SETUP: sck=0 for CLK_DIV cycles. On tick, go to XFER with sck=1.
- XFER, 2*DATA_W half-periods:
  - Entering a high phase (sck 0->1) samples miso into the shift register LSB in the same clk cycle sck goes high.
  - Entering a low phase (sck 1->0) shifts left and puts the next bit on mosi.
  - After the DATA_W-th falling edge, go to HOLD. sck stays low and mosi holds its last value.
- HOLD: CLK_DIV cycles. On tick:
  - data_out <= shift register; done=1 for one cycle.
  - If latched keep_ss=0: ss=1 and go to GAP.
  - If latched keep_ss=1: busy=0, go to IDLE, ss stays 0.
- GAP: ss=1 for CLK_DIV cycles; busy=1. On tick, busy=0 and go to IDLE.
- Latency, with the start cycle as cycle 0:
  - ss falls at cycle 1.
  - First sck rise at cycle 1+CLK_DIV.
  - done at cycle 1+18*CLK_DIV (73 for the defaults).
  - busy falls at cycle 1+19*CLK_DIV without keep_ss, or at the done cycle with keep_ss.
- start while busy=1 is ignored; there is no queuing.
- start asserted in the same cycle busy falls is ignored. It is accepted on the first cycle with busy=0.
- Burst: a start in IDLE while ss=0 enters SETUP without glitching ss.
- When a transfer completes with keep_ss=0 latched, ss deasserts even if the previous byte held it.
- data_in changes after start have no effect.
- miso is used without a synchronizer. The slave shifts on falling sck, so miso is stable at least CLK_DIV-1 cycles before sampling.

Decomposition:
- Shared package spi_pkg holds:
  - state enum (IDLE, SETUP, XFER, HOLD, GAP);
  - SPI_DATA_W=8;
  - SPI_MIN_DIV=2.
- One natural sub-module, spi_tick_div: a CLK_DIV counter with clear input and tick output. The FSM and shift register stay in spi_master.

Test Plan:
- Loopback, defaults: mosi tied to miso, start with data_in=0xA5.
  - done at cycle 73, data_out=0xA5.
  - sck shows 8 pulses, each high 4 and low 4 cycles.
  - ss low from cycle 1 to 72 and high at 73.
- Slave model returns 0x3C while master sends 0xC3.
  - Slave captures 0xC3; data_out=0x3C.
  - mosi is stable across every sck rising edge.
- Burst: start 0x12 with keep_ss=1, then at the first idle cycle start 0x34 with keep_ss=0.
  - ss stays low through both bytes; two done pulses with data_out 0x12 then 0x34 in loopback.
  - ss high for 4 cycles after the second done.
- start pulsed at cycles 10 and 40 during a transfer: ignored, exactly one done, busy continuous until cycle 77.
- rst asserted at cycle 30 mid-XFER: next cycle ss=1, sck=0, busy=0, done never pulses, data_out=0. A new start afterwards completes normally.
- CLK_DIV=2, send 0xFF to a miso held at 0: sck period 4 cycles, done at cycle 37, data_out=0x00.
